// File: rtl/div_afu_pkg.sv
// Shared definitions for the division AFU.
// Provides the default quotient width, divider latency and cache-line width,
// the lane / line data types, and the fill-buffer state enumeration used by
// div_result_packer.
package div_afu_pkg;

  localparam int DIV_DATA_LEN = 32;
  localparam int DIV_LATENCY  = 10;
  localparam int CL_BITS      = 512;
  localparam int DIV_LANES    = CL_BITS / DIV_DATA_LEN;

  typedef logic [DIV_DATA_LEN-1:0] t_div_lane;
  typedef logic [CL_BITS-1:0]      t_cl_data;

  // FILLING  : the fill buffer accepts quotients.
  // FULL_WAIT: the fill buffer holds a complete line and waits for the output slot.
  typedef enum logic {FILLING, FULL_WAIT} t_pack_state;

endpackage

// File: rtl/div_result_packer_if.sv
// Cache-line output handshake of div_result_packer.
// Signals:
//   line_valid  producer -> consumer  a line is held and valid
//   line_ready  consumer -> producer  consumer accepts (transfer on valid && ready)
//   line_data   producer -> consumer  lane i at bits [i*DATA_LEN +: DATA_LEN]
//   line_count  producer -> consumer  number of valid lanes (1..LANES)
//   line_last   producer -> consumer  line was produced by a flush
// Modports: master (packer side), slave (write-request side).
interface div_result_packer_if
  import div_afu_pkg::*;
#(
  parameter int DATA_LEN = DIV_DATA_LEN,
  parameter int CL_BITS  = div_afu_pkg::CL_BITS
);

  localparam int LANES = CL_BITS / DATA_LEN;
  localparam int CNT_W = $clog2(LANES) + 1;

  logic               line_valid;
  logic               line_ready;
  logic [CL_BITS-1:0] line_data;
  logic [CNT_W-1:0]   line_count;
  logic               line_last;

  modport master (
    output line_valid,
    output line_data,
    output line_count,
    output line_last,
    input  line_ready
  );

  modport slave (
    input  line_valid,
    input  line_data,
    input  line_count,
    input  line_last,
    output line_ready
  );

endinterface

// File: rtl/div_result_packer_delay_line.sv
// valid_delay_line: shift register that replays issue_valid DEPTH cycles later,
// tracking when the divider's fixed-latency output becomes valid.
// Ports:
//   clk, reset (synchronous, active-high)
//   in_valid   an operand pair entered the divider this cycle
//   out_valid  the matching result is on the divider output this cycle
module valid_delay_line #(
  parameter int DEPTH = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] taps;

  // Tap k is high k+1 cycles after the issue was sampled.
  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (reset) taps <= '0;
        else       taps <= in_valid;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (reset) taps <= '0;
        else       taps <= {taps[DEPTH-2:0], in_valid};
      end
    end
  endgenerate

  assign out_valid = taps[DEPTH-1];

endmodule

// File: rtl/div_result_packer.sv
// div_result_packer: captures quotients from the fixed-latency divider, packs
// them into cache lines and presents full or flushed lines on a valid/ready
// handshake. A fill buffer plus an output slot form a two-line ping-pong so
// packing continues while write-back is stalled.
// Optional feature macro: DIV_PACKER_STATS_EN adds stat_lines / stat_drops.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   issue_valid      operand pair entered the divider this cycle
//   div_result       divider output, used only when the delay line says valid
//   flush            request to emit the partially filled line
//   line_if          output line handshake (master modport)
//   overflow         sticky: a result was dropped
//   busy             work in flight, buffered, held, or flush pending
//   stat_lines       (stats build) saturating count of lines accepted
//   stat_drops       (stats build) saturating count of dropped results
module div_result_packer
  import div_afu_pkg::*;
#(
  parameter int DATA_LEN = DIV_DATA_LEN,
  parameter int LATENCY  = DIV_LATENCY,
  parameter int CL_BITS  = div_afu_pkg::CL_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [DATA_LEN-1:0] div_result,
  input  logic                flush,
  div_result_packer_if.master line_if,
  output logic                overflow,
  output logic                busy
`ifdef DIV_PACKER_STATS_EN
  ,
  output logic [31:0]         stat_lines,
  output logic [31:0]         stat_drops
`endif
);

  localparam int LANES = CL_BITS / DATA_LEN;
  localparam int CNT_W = $clog2(LANES) + 1;
  localparam int FLT_W = $clog2(LATENCY + 1);

  logic res_valid;

  valid_delay_line #(.DEPTH(LATENCY)) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue_valid),
    .out_valid (res_valid)
  );

  t_pack_state        state_q, state_d;
  logic [FLT_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [CL_BITS-1:0] fill_q, fill_d;
  logic               flush_pend_q, flush_pend_d;
  logic               line_valid_q, line_valid_d;
  logic [CL_BITS-1:0] line_data_q, line_data_d;
  logic [CNT_W-1:0]   line_count_q, line_count_d;
  logic               line_last_q, line_last_d;
  logic               overflow_q, overflow_d;

  logic               accept, slot_free, capture, drop, flush_fire;
  logic               load, load_last;
  logic [CNT_W-2:0]   lane_idx;
  logic [CL_BITS-1:0] staged;
  logic [CNT_W-1:0]   staged_cnt;

  assign lane_idx = fill_cnt_q[CNT_W-2:0];

  // Next-state logic. "staged" is the fill buffer including this cycle's
  // capture, so a result landing in the last lane is part of the line that
  // hands off on the same edge.
  always_comb begin
    accept     = line_valid_q && line_if.line_ready;
    slot_free  = !line_valid_q || accept;
    capture    = res_valid && (state_q == FILLING);
    drop       = res_valid && (state_q == FULL_WAIT);
    flush_fire = flush_pend_q && (inflight_q == '0) && (state_q == FILLING);

    staged = fill_q;
    if (capture) staged[int'(lane_idx)*DATA_LEN +: DATA_LEN] = div_result;
    staged_cnt = fill_cnt_q + CNT_W'(capture);

    state_d      = state_q;
    inflight_d   = inflight_q + FLT_W'(issue_valid) - FLT_W'(res_valid);
    fill_d       = staged;
    fill_cnt_d   = staged_cnt;
    flush_pend_d = flush_pend_q;
    line_valid_d = line_valid_q && !accept;
    line_data_d  = line_data_q;
    line_count_d = line_count_q;
    line_last_d  = line_last_q;
    overflow_d   = overflow_q || drop;
    load         = 1'b0;
    load_last    = 1'b0;

    case (state_q)
      FILLING: begin
        if (staged_cnt == CNT_W'(LANES)) begin
          if (slot_free) load = 1'b1;
          else           state_d = FULL_WAIT;
        end else if (flush_fire) begin
          // An empty flush completes immediately; a partial one waits for the slot.
          if (fill_cnt_q == '0) begin
            flush_pend_d = 1'b0;
          end else if (slot_free) begin
            load         = 1'b1;
            load_last    = 1'b1;
            flush_pend_d = 1'b0;
          end
        end
      end
      FULL_WAIT: begin
        if (accept) begin
          load    = 1'b1;
          state_d = FILLING;
        end
      end
      default: state_d = FILLING;
    endcase

    // Lanes beyond the valid count are zeroed; stale fill data never leaks out.
    if (load) begin
      line_valid_d = 1'b1;
      line_count_d = staged_cnt;
      line_last_d  = load_last;
      fill_cnt_d   = '0;
      for (int i = 0; i < LANES; i++) begin
        if (i < int'(staged_cnt)) line_data_d[i*DATA_LEN +: DATA_LEN] = staged[i*DATA_LEN +: DATA_LEN];
        else                      line_data_d[i*DATA_LEN +: DATA_LEN] = '0;
      end
    end

    if (flush) flush_pend_d = 1'b1;
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILLING;
      inflight_q   <= '0;
      fill_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      line_valid_q <= 1'b0;
      line_data_q  <= '0;
      line_count_q <= '0;
      line_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      fill_cnt_q   <= fill_cnt_d;
      flush_pend_q <= flush_pend_d;
      line_valid_q <= line_valid_d;
      line_data_q  <= line_data_d;
      line_count_q <= line_count_d;
      line_last_q  <= line_last_d;
      overflow_q   <= overflow_d;
    end
  end

  // Fill lane storage needs no reset: fill_cnt decides which lanes are live.
  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

  assign line_if.line_valid = line_valid_q;
  assign line_if.line_data  = line_data_q;
  assign line_if.line_count = line_count_q;
  assign line_if.line_last  = line_last_q;
  assign overflow           = overflow_q;
  assign busy               = (inflight_q != '0) || (fill_cnt_q != '0) || line_valid_q || flush_pend_q;

`ifdef DIV_PACKER_STATS_EN
  logic [31:0] stat_lines_q, stat_drops_q;

  // Saturating counters read back through CSRs 0 and 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lines_q <= '0;
      stat_drops_q <= '0;
    end else begin
      if (accept && (stat_lines_q != '1)) stat_lines_q <= stat_lines_q + 32'd1;
      if (drop && (stat_drops_q != '1))   stat_drops_q <= stat_drops_q + 32'd1;
    end
  end

  assign stat_lines = stat_lines_q;
  assign stat_drops = stat_drops_q;
`endif

endmodule

// File: tb/tb_div_result_packer.sv
// Self-checking bench for div_result_packer. The bench plays the divider
// (replays each issued value LATENCY cycles later) and predicts output lines
// from issue order: every 16 issued values form a line, a flush closes the
// current partial line.
`timescale 1ns/1ps
module tb_div_result_packer;
  import div_afu_pkg::*;

  localparam int LAT = DIV_LATENCY;
  localparam int DW  = DIV_DATA_LEN;
  localparam int NL  = CL_BITS / DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic          flush;
  logic [DW-1:0] div_result;
  logic          overflow;
  logic          busy;
`ifdef DIV_PACKER_STATS_EN
  logic [31:0]   stat_lines;
  logic [31:0]   stat_drops;
`endif

  div_result_packer_if #(.DATA_LEN(DW), .CL_BITS(CL_BITS)) line_bus ();

  div_result_packer #(.DATA_LEN(DW), .LATENCY(LAT), .CL_BITS(CL_BITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .div_result  (div_result),
    .flush       (flush),
    .line_if     (line_bus.master),
    .overflow    (overflow),
    .busy        (busy)
`ifdef DIV_PACKER_STATS_EN
    ,
    .stat_lines  (stat_lines),
    .stat_drops  (stat_drops)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CL_BITS-1:0] data;
    int                 count;
    bit                 last;
  } line_t;

  line_t         exp_q[$];
  logic [DW-1:0] cur_q[$];
  logic [DW-1:0] pipe[LAT];
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string tag, input logic [CL_BITS-1:0] obs, input logic [CL_BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void emitLine(input bit last);
    line_t l;
    l.data = '0;
    foreach (cur_q[i]) l.data[i*DW +: DW] = cur_q[i];
    l.count = cur_q.size();
    l.last  = last;
    exp_q.push_back(l);
    cur_q.delete();
  endfunction

  function automatic void modelIssue(input logic [DW-1:0] v);
    cur_q.push_back(v);
    if (cur_q.size() == NL) emitLine(1'b0);
  endfunction

  function automatic void modelFlush();
    if (cur_q.size() > 0) emitLine(1'b1);
  endfunction

  // One clock cycle: drive inputs, check any accepted line at the falling
  // edge, then advance the divider model on the rising edge.
  task automatic applyStimulus(input bit iv, input logic [DW-1:0] val, input bit fl,
                               input bit rdy, input bit modelled);
    line_t e;
    issue_valid         = iv;
    flush               = fl;
    line_bus.line_ready = rdy;
    div_result          = pipe[LAT-1];
    if (iv && modelled) modelIssue(val);
    if (fl && modelled) modelFlush();
    @(negedge clk);
    if (line_bus.line_valid === 1'b1 && line_bus.line_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_line", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("line_data", line_bus.line_data, e.data);
        checkOutput("line_count", line_bus.line_count, e.count);
        checkOutput("line_last", line_bus.line_last, e.last);
      end
    end
    @(posedge clk);
    for (int i = LAT-1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = val;
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
      n++;
    end
    checkOutput("drain_idle", busy, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    cur_q.delete();
  endtask

  // 33 results into a stalled consumer: two lines buffered, the 33rd dropped.
  task automatic runOverflowBurst();
    for (int k = 0; k < 33; k++) applyStimulus(1'b1, DW'(101 + k), 1'b0, 1'b0, k < 32);
    repeat (LAT + 2) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_held_valid", line_bus.line_valid, 1);
    checkOutput("ovf_held_data", line_bus.line_data, exp_q[0].data);
    checkOutput("ovf_held_count", line_bus.line_count, NL);
    checkOutput("ovf_pending_lines", exp_q.size(), 2);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_still_held", line_bus.line_data, exp_q[0].data);
    drain(60);
    checkOutput("ovf_delivered", exp_q.size(), 0);
  endtask

  initial begin
    int low_run;
    int pause;
    foreach (pipe[i]) pipe[i] = '0;
    issue_valid         = 1'b0;
    flush               = 1'b0;
    div_result          = '0;
    line_bus.line_ready = 1'b0;

    // Reset values
    doReset();
    checkOutput("rst_valid", line_bus.line_valid, 0);
    checkOutput("rst_data", line_bus.line_data, 0);
    checkOutput("rst_count", line_bus.line_count, 0);
    checkOutput("rst_last", line_bus.line_last, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_busy", busy, 0);

    // 16 back-to-back results 1..16 with line_valid timing
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, DW'(k + 1), 1'b0, 1'b1, 1'b1);
    repeat (LAT - 1) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("full_valid_before", line_bus.line_valid, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("full_valid_at", line_bus.line_valid, 1);
    drain(40);
    checkOutput("full_delivered", exp_q.size(), 0);

    // 3 results then flush -> partial line
    applyStimulus(1'b1, DW'(7), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, DW'(8), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, DW'(9), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
    drain(40);
    checkOutput("partial_delivered", exp_q.size(), 0);

    // Stalled consumer: overflow and ordered delivery
    runOverflowBurst();

    // Flush together with the last of 5 issues
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, DW'(201 + k), k == 4, 1'b1, 1'b1);
    repeat (LAT) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_waits", line_bus.line_valid, 0);
    checkOutput("flush_pending_lines", exp_q.size(), 1);
    drain(40);
    checkOutput("flush5_delivered", exp_q.size(), 0);

    // Reset with 8 captured and 4 in flight
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, DW'(301 + k), 1'b0, 1'b0, 1'b0);
    repeat (LAT - 4) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("midrst_valid", line_bus.line_valid, 0);
    checkOutput("midrst_data", line_bus.line_data, 0);
    checkOutput("midrst_count", line_bus.line_count, 0);
    checkOutput("midrst_last", line_bus.line_last, 0);
    checkOutput("midrst_overflow", overflow, 0);
    checkOutput("midrst_busy", busy, 0);
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, DW'(401 + k), 1'b0, 1'b1, 1'b1);
    drain(60);
    checkOutput("postrst_delivered", exp_q.size(), 0);

    // Random issues, values, flushes and short consumer stalls
    low_run = 0;
    pause   = 0;
    for (int c = 0; c < 800; c++) begin
      bit            iv;
      bit            fl;
      bit            rdy;
      logic [DW-1:0] v;
      rdy     = ($urandom_range(0, 3) != 0) || (low_run >= 8);
      low_run = rdy ? 0 : low_run + 1;
      iv      = (pause == 0) && ($urandom_range(0, 3) != 0);
      fl      = (pause == 0) && ($urandom_range(0, 40) == 0);
      v       = $urandom;
      if (fl)             pause = 24;
      else if (pause > 0) pause--;
      applyStimulus(iv, v, fl, rdy, 1'b1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
    drain(200);
    checkOutput("rand_delivered", exp_q.size(), 0);
    checkOutput("rand_no_overflow", overflow, 0);

`ifdef DIV_PACKER_STATS_EN
    // Two accepted lines and one drop
    doReset();
    checkOutput("stat_lines_rst", stat_lines, 0);
    runOverflowBurst();
    checkOutput("stat_lines", stat_lines, 2);
    checkOutput("stat_drops", stat_drops, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_result_packer.md
# div_result_packer

Downstream stage of the pipelined `divider` in the division AFU. It tracks operand issues through the divider's fixed latency and captures each quotient when it emerges. Quotients are packed into 512-bit cache lines, and full or flushed lines are presented to the write-request logic over a valid/ready handshake. A two-line ping-pong buffer lets packing continue while write-back is stalled.

## Interface
Parameters:
- `DATA_LEN`, 32: quotient width in bits.
- `LATENCY`, 10: cycles from the `issue_valid` sample edge to the matching `div_result` being valid. Minimum 1.
- `CL_BITS`, 512: cache-line width.
- `LANES`, `CL_BITS/DATA_LEN` (16): localparam, quotients per line.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  an operand pair entered the divider this cycle.
- `div_result`  in  `DATA_LEN`  divider output, sampled only when the internal delay line says valid.
- `flush`  in  1  single-cycle request to emit the partially filled line.
- `line_valid`  out  1  output line is held and valid.
- `line_ready`  in  1  consumer accepts the line; transfer occurs when valid && ready.
- `line_data`  out  `CL_BITS`  lane i at bits [i*DATA_LEN +: DATA_LEN].
- `line_count`  out  `$clog2(LANES)+1`  number of valid lanes, 1..LANES.
- `line_last`  out  1  line was produced by a flush.
- `overflow`  out  1  sticky; a result was dropped.
- `busy`  out  1  in-flight count != 0, or fill count != 0, or `line_valid`, or flush pending.

## Operation
- Delay line: `LATENCY`-bit shift register of `issue_valid`; `res_valid` = tap `LATENCY-1`. An in-flight counter increments on issue and decrements on `res_valid`; both in one cycle leaves it unchanged.
- Fill buffer: on `res_valid`, write `div_result` into lane `fill_cnt` and increment `fill_cnt`.
- Hand-off from fill to output occurs when any of these holds:
  - `fill_cnt` reaches `LANES`;
  - a flush fires with `fill_cnt` > 0.
- Hand-off rules:
  - Allowed when the output slot is empty or is being accepted in the same cycle.
  - Otherwise the fill buffer stays full (state FULL_WAIT) until the output slot frees.
  - Unused lanes are zeroed.
- Fill FSM:
  - FILLING -> FULL_WAIT on `fill_cnt == LANES` with the output slot occupied.
  - FULL_WAIT -> FILLING on output accept; the full line moves to the output slot and `fill_cnt` = 0.
- Overflow: `res_valid` in FULL_WAIT drops the result and sets `overflow`, which clears only on reset. The divider cannot be stalled.
- Flush handling:
  - `flush` sets `flush_pend`.
  - The flush fires when the in-flight count is 0 and the fill FSM is in FILLING.
  - `fill_cnt` > 0: emit a partial line with `line_last` = 1.
  - `fill_cnt` = 0: clear `flush_pend` and emit nothing.
  - `flush` while `flush_pend` is already set: no additional effect.
  - `flush` in the same cycle as `issue_valid`: that issue is in flight, so the flush waits for it.
- Simultaneous `res_valid` and hand-off of lane `LANES-1`: the result lands in lane `LANES-1` before the transfer.

## Timing
- Reset values: delay line, counters, `flush_pend`, `line_valid`, `line_last`, `overflow`, `busy` = 0; `line_data` = 0; `line_count` = 0.
- `issue_valid` at cycle t: result captured at the edge ending cycle t+LATENCY.
- `line_valid` rises on the edge of the capture that filled lane `LANES-1`, or on the edge that fired the flush.
- Output is held stable while `line_valid` && !`line_ready`; it drops the cycle after accept unless a new line loads on that same edge.
- Sustained throughput: 1 result/cycle with `line_ready` high.
- Reset mid-operation discards all in-flight and buffered data in one cycle; the divider is reset concurrently.

## Configuration
- `DIV_PACKER_STATS_EN` defined: adds outputs `stat_lines` (32, lines accepted) and `stat_drops` (32, dropped results).
  - Both are saturating and cleared by reset.
  - They are exposed for read CSRs 0/1.
- Not defined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `div_afu_pkg`:
  - `DIV_DATA_LEN` = 32, `DIV_LATENCY` = 10, `CL_BITS` = 512;
  - `t_div_lane`, `t_cl_data`;
  - fill FSM enum `t_pack_state {FILLING, FULL_WAIT}`.
- One sub-module is natural: `valid_delay_line`, parameterised by depth, producing `res_valid`.

## Test plan
- 16 back-to-back issues with results 1..16, `line_ready` = 1 -> one line, lanes 0..15 = 1..16, `line_count` = 16, `line_last` = 0, `line_valid` high on the edge ending cycle 15+LATENCY.
- 3 issues (results 7, 8, 9), then `flush` -> after drain, line lanes 0..2 = 7, 8, 9, lanes 3..15 = 0, `line_count` = 3, `line_last` = 1.
- `line_ready` = 0, 33 results -> first line held unchanged, fill buffer full, 33rd result dropped, `overflow` = 1; raising `line_ready` delivers both lines in order.
- `flush` in the same cycle as the last of 5 issues -> no line before that result arrives; then one line with `line_count` = 5.
- `reset` after 8 captures with 4 results in flight -> all outputs 0, `busy` = 0; stale results are ignored and the next 16 issues produce a clean line.
- With `DIV_PACKER_STATS_EN`: two full lines accepted plus one drop -> `stat_lines` = 2, `stat_drops` = 1.
